// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone initiator running FIFO-queued register read/write commands, one single cycle at a time.
// Optional ACK timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_cmd_master #(
  parameter int ADDRWIDTH = 7,
  parameter int DATAWIDTH = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter logic [DATAWIDTH-1:0] ERR_DATA = 32'hDEAD_0BAD
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_sel_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int EW = 5 + ADDRWIDTH + DATAWIDTH;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
  state_t state;
  logic [EW-1:0] fifo [CMD_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic push, pop, expire;
  logic h_we;
  logic [ADDRWIDTH-1:0] h_adr;
  logic [DATAWIDTH-1:0] h_dat;
  logic [3:0] h_sel;
  // full is the top count bit since CMD_DEPTH is a power of two
  assign cmd_ready_o = !cnt[PW];
  assign push = cmd_valid_i && cmd_ready_o;
  assign pop = state == IDLE && cnt != '0;
  assign busy_o = cnt != '0 || state != IDLE;
  assign {h_we, h_adr, h_dat, h_sel} = fifo[rp];
  assign WBm_STB_o = WBm_CYC_o;
  always_ff @(posedge WBs_CLK_i)
    if (push) fifo[wp] <= {cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i};
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
    if (WBs_RST_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic err_q;
  assign expire = tmo == TW'(TIMEOUT_CYCLES - 1);
  assign rsp_err_o = err_q;
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
    if (WBs_RST_i) begin
      tmo <= '0;
      err_q <= 1'b0;
    end else begin
      tmo <= state == REQ ? tmo + 1'b1 : '0;
      if (state == REQ && (WBm_ACK_i || expire)) err_q <= !WBm_ACK_i;
    end
`else
  logic unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES != 0;
  assign expire = 1'b0;
  assign rsp_err_o = 1'b0;
`endif
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i)
    if (WBs_RST_i) begin
      state <= IDLE;
      WBm_CYC_o <= 1'b0;
      WBm_WE_o <= 1'b0;
      WBm_ADR_o <= '0;
      WBm_BYTE_STB_o <= '0;
      WBm_DAT_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          state <= REQ;
          WBm_CYC_o <= 1'b1;
          WBm_WE_o <= h_we;
          WBm_ADR_o <= h_adr;
          WBm_BYTE_STB_o <= h_sel;
          WBm_DAT_o <= h_dat;
        end
        REQ: if (WBm_ACK_i || expire) begin
          state <= RSP;
          WBm_CYC_o <= 1'b0;
          rsp_valid_o <= 1'b1;
          rsp_dat_o <= !WBm_ACK_i ? ERR_DATA : WBm_WE_o ? '0 : WBm_DAT_i;
        end
        RSP: if (rsp_ready_i) begin
          state <= IDLE;
          rsp_valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: scoreboard bench for wb_cmd_master against a 64-word register bank client model.
module tb_wb_cmd_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_we = 0, rsp_ready = 1;
  logic [6:0] cmd_adr = 0;
  logic [31:0] cmd_dat = 0;
  logic [3:0] cmd_sel = 0;
  logic cmd_ready, rsp_valid, rsp_err, busy, cyc, stb, we;
  logic [31:0] rsp_dat, wdat, rdat;
  logic [6:0] adr;
  logic [3:0] bsel;
  logic ack, ack_r = 0, ack_pulse = 0, ack_en = 1;
  logic [31:0] bank [64];
  typedef struct {logic [31:0] d; logic e;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc_rises = 0, cyc_hi = 0;
  logic cyc_prev = 0;
  logic [3:0] last_sel = 0;

  always #5 clk = ~clk;

  wb_cmd_master dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .WBm_ADR_o(adr), .WBm_CYC_o(cyc), .WBm_STB_o(stb), .WBm_WE_o(we),
    .WBm_BYTE_STB_o(bsel), .WBm_DAT_o(wdat), .WBm_DAT_i(rdat), .WBm_ACK_i(ack)
  );

  // client: registered one-cycle ACK, unmapped addresses read a fixed pattern
  assign ack = ack_r | ack_pulse;
  assign rdat = adr < 7'd64 ? bank[adr[5:0]] : 32'hFABD_EFAC;
  initial for (int i = 0; i < 64; i++) bank[i] = 0;
  always @(posedge clk) begin
    if (ack_r && we && cyc && adr < 7'd64)
      for (int b = 0; b < 4; b++) if (bsel[b]) bank[adr[5:0]][8*b +: 8] <= wdat[8*b +: 8];
    ack_r <= ack_en && cyc && stb && !ack_r;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cyc && !cyc_prev) cyc_rises++;
    cyc_prev = cyc;
    if (cyc) begin
      cyc_hi++;
      last_sel = bsel;
      chk("stb_eq_cyc", {31'd0, stb}, {31'd0, cyc});
    end
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_dat", rsp_dat, e.d);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.e});
      end
    end
  end

  task automatic push(input logic w, input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] ed, input logic ee, input bit track);
    int n;
    cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    for (n = 0; n < 200 && !cmd_ready; n++) @(negedge clk);
    if (n == 200) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    if (track) sb.push_back('{ed, ee});
    #1 cmd_valid = 0;
  endtask

  task automatic drain();
    int n;
    for (n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    chk("drain_left", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000 $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rspd", rsp_dat, 32'd0);
    rst = 0;
    @(negedge clk);
    // write then read back
    push(1, 7'h10, 32'h1234_5678, 4'hF, 32'h0, 0, 1);
    push(0, 7'h10, 32'h0, 4'hF, 32'h1234_5678, 0, 1);
    drain();
    // partial byte strobes over a cleared word
    push(1, 7'h18, 32'h0, 4'hF, 32'h0, 0, 1);
    push(1, 7'h18, 32'hAABB_CCDD, 4'b0101, 32'h0, 0, 1);
    drain();
    chk("byte_stb", {28'd0, last_sel}, 32'h5);
    push(0, 7'h18, 32'h0, 4'hF, 32'h00BB_00DD, 0, 1);
    drain();
    // fill FIFO under response backpressure
    rsp_ready = 0;
    cyc_rises = 0;
    push(1, 7'h20, 32'h1, 4'hF, 32'h0, 0, 1);
    push(1, 7'h21, 32'h2, 4'hF, 32'h0, 0, 1);
    push(0, 7'h20, 32'h0, 4'hF, 32'h1, 0, 1);
    push(0, 7'h21, 32'h0, 4'hF, 32'h2, 0, 1);
    push(1, 7'h22, 32'h3, 4'hF, 32'h0, 0, 1);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    repeat (6) @(negedge clk);
    chk("one_cycle_issued", cyc_rises, 32'd1);
    chk("bp_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    rsp_ready = 1;
    drain();
    chk("drained_cycles", cyc_rises, 32'd5);
    // unmapped read
    push(0, 7'h7C, 32'h0, 4'hF, 32'hFABD_EFAC, 0, 1);
    drain();
`ifdef WB_MASTER_TIMEOUT_EN
    ack_en = 0;
    push(0, 7'h10, 32'h0, 4'hF, 32'hDEAD_0BAD, 1, 1);
    cyc_hi = 0;
    drain();
    chk("tmo_cyc_len", cyc_hi, 32'd16);
    ack_en = 1;
`endif
    // reset while a cycle is in flight
    ack_en = 0;
    push(0, 7'h10, 32'h0, 4'hF, 32'h0, 0, 0);
    for (n = 0; n < 20 && !cyc; n++) @(negedge clk);
    chk("pre_rst_cyc", {31'd0, cyc}, 32'd1);
    rst = 1;
    #1;
    chk("rst_mid_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    ack_en = 1;
    push(0, 7'h10, 32'h0, 4'hF, 32'h1234_5678, 0, 1);
    drain();
    // stray ACK while idle, then exact latency of a single read
    ack_pulse = 1;
    @(negedge clk);
    ack_pulse = 0;
    repeat (2) @(negedge clk);
    chk("stray_ack", {29'd0, cyc, rsp_valid, busy}, 32'd0);
    push(0, 7'h20, 32'h0, 4'hF, 32'h1, 0, 1);
    chk("lat_n0_cyc", {31'd0, cyc}, 32'd0);
    @(posedge clk); #1;
    chk("lat_n1_cyc", {31'd0, cyc}, 32'd1);
    chk("lat_n1_rspv", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_n2_ack", {31'd0, ack}, 32'd1);
    @(posedge clk); #1;
    chk("lat_n3_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("lat_n3_cyc", {31'd0, cyc}, 32'd0);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
